serial_compare_ctrl: RTL and testbench

SERIAL_COMPARE_CTRL -- requirements
Module: serial_compare_ctrl

---
 rtl/serial_compare_ctrl_if.sv | 24 ++
 rtl/serial_compare_ctrl.sv | 105 ++++++++++
 tb/tb_serial_compare_ctrl.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/serial_compare_ctrl_if.sv
// Handshake and result bundle for the bit-serial comparator.
interface serial_compare_ctrl_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             busy;
    logic             done;
    logic             o_gt;
    logic             o_eq;
    logic             o_lt;
    logic [5:0]       bits_used;

    modport master (
        output start, x, y,
        input  busy, done, o_gt, o_eq, o_lt, bits_used
    );

    modport slave (
        input  start, x, y,
        output busy, done, o_gt, o_eq, o_lt, bits_used
    );
endinterface

// File: rtl/serial_compare_ctrl.sv
// Bit-serial unsigned magnitude comparator: one bit per cycle, MSB first,
// stopping early at the first differing bit.
//
// state | meaning
// IDLE  | waiting for start; last results held
// RUN   | examining bit idx of the captured operands
// DONE  | one-cycle result strobe, then back to IDLE
module serial_compare_ctrl #(
    parameter int WIDTH = 16
) (
    input logic                  clk,
    input logic                  rst_n,
    serial_compare_ctrl_if.slave cmp
);
    localparam int IDX_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] x_q;
    logic [WIDTH-1:0] y_q;
    logic [IDX_W-1:0] idx;
    logic             gt;
    logic             eq;
    logic             busy_q;
    logic             done_q;
    logic             gt_q;
    logic             eq_q;
    logic             lt_q;
    logic [5:0]       bits_q;

    logic xb, yb, gt_next, eq_next;

    always_comb begin
        xb      = x_q[idx];
        yb      = y_q[idx];
        gt_next = gt | (eq & xb & ~yb);
        eq_next = eq & ~(xb ^ yb);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            x_q    <= '0;
            y_q    <= '0;
            idx    <= IDX_MAX;
            gt     <= 1'b0;
            eq     <= 1'b1;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            gt_q   <= 1'b0;
            eq_q   <= 1'b0;
            lt_q   <= 1'b0;
            bits_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmp.start) begin
                        x_q    <= cmp.x;
                        y_q    <= cmp.y;
                        gt     <= 1'b0;
                        eq     <= 1'b1;
                        idx    <= IDX_MAX;
                        bits_q <= '0;
                        busy_q <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    gt     <= gt_next;
                    eq     <= eq_next;
                    bits_q <= bits_q + 6'd1;
                    // Once the operands differ the remaining bits cannot change the verdict.
                    if (!eq_next || idx == '0) begin
                        done_q <= 1'b1;
                        gt_q   <= gt_next;
                        eq_q   <= eq_next;
                        lt_q   <= ~gt_next & ~eq_next;
                        state  <= DONE;
                    end else begin
                        idx <= idx - 1'b1;
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign cmp.busy      = busy_q;
    assign cmp.done      = done_q;
    assign cmp.o_gt      = gt_q;
    assign cmp.o_eq      = eq_q;
    assign cmp.o_lt      = lt_q;
    assign cmp.bits_used = bits_q;
endmodule

// File: tb/tb_serial_compare_ctrl.sv
// Self-checking bench for serial_compare_ctrl (WIDTH=16): cycle model plus directed cases.
module tb_serial_compare_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;

    serial_compare_ctrl_if #(.WIDTH(16)) cmp();

    serial_compare_ctrl #(.WIDTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .cmp   (cmp.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // k = number of bits examined: position of first differing bit from the MSB, or 16 if equal.
    function automatic int calc_k(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] d;
        d = a ^ b;
        for (int p = 15; p >= 0; p--)
            if (d[p]) return 16 - p;
        return 16;
    endfunction

    function automatic logic [2:0] calc_res(input logic [15:0] a, input logic [15:0] b);
        if (a > b) return 3'b100;
        if (a == b) return 3'b010;
        return 3'b001;
    endfunction

    // Behavioural model: counts edges since acceptance against a precomputed k.
    bit         m_active = 0;
    bit         m_busy = 0;
    bit         m_done = 0;
    logic [2:0] m_res = 3'b000;
    logic [2:0] p_res = 3'b000;
    int         m_bits = 0;
    int         m_cnt = 0;
    int         m_k = 0;
    int         m_accepts = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active = 0; m_busy = 0; m_done = 0; m_res = 3'b000; m_bits = 0;
        end else if (!m_active) begin
            m_done = 0;
            if (cmp.start) begin
                m_active = 1;
                m_cnt    = 0;
                m_k      = calc_k(cmp.x, cmp.y);
                p_res    = calc_res(cmp.x, cmp.y);
                m_busy   = 1;
                m_bits   = 0;
                m_accepts++;
            end
        end else begin
            m_cnt++;
            if (m_cnt <= m_k) m_bits = m_cnt;
            if (m_cnt == m_k) begin
                m_done = 1;
                m_res  = p_res;
            end else begin
                m_done = 0;
                if (m_cnt > m_k) begin
                    m_active = 0;
                    m_busy   = 0;
                end
            end
        end
    end

    bit b2b = 0;
    bit have_prev = 0;
    int prev_done = 0;

    always begin
        @(posedge clk);
        #1;
        cyc++;
        chk("cycle_outputs",
            int'({cmp.busy, cmp.done, cmp.o_gt, cmp.o_eq, cmp.o_lt, cmp.bits_used}),
            int'({m_busy, m_done, m_res, 6'(m_bits)}));
        if (cmp.done) begin
            if (b2b && have_prev) chk("done_spacing", cyc - prev_done, m_k + 2);
            prev_done = cyc;
            have_prev = 1;
        end
    end

    task automatic directed(input string nm, input logic [15:0] a, input logic [15:0] b,
                            input int ek, input int eres, input int poke);
        int lat = -1;
        int busy_cnt = 0;
        int dones = 0;
        bit ended = 0;
        @(posedge clk); #3;
        cmp.x = a; cmp.y = b; cmp.start = 1'b1;
        @(posedge clk); #1;
        for (int j = 0; j < 40; j++) begin
            if (j > 0) begin @(posedge clk); #1; end
            if (!cmp.busy) begin ended = 1; break; end
            busy_cnt++;
            if (cmp.done) begin dones++; lat = j; end
            #2;
            if (j == 0) cmp.start = 1'b0;
            if (poke > 0 && j == poke) begin
                cmp.start = 1'b1; cmp.x = ~a; cmp.y = 16'($urandom);
            end
            if (poke > 0 && j == poke + 1) cmp.start = 1'b0;
        end
        chk({nm, "_ended"}, int'(ended), 1);
        chk({nm, "_latency"}, lat, ek);
        chk({nm, "_busy_cycles"}, busy_cnt, ek + 1);
        chk({nm, "_done_pulses"}, dones, 1);
        chk({nm, "_result"}, int'({cmp.o_gt, cmp.o_eq, cmp.o_lt}), eres);
        chk({nm, "_bits_used"}, int'(cmp.bits_used), ek);
    endtask

    initial begin
        int dones;
        int base;
        logic [31:0] r;
        rst_n = 1'b0; cmp.start = 1'b0; cmp.x = '0; cmp.y = '0;
        #12;
        chk("reset_state", int'({cmp.busy, cmp.done, cmp.o_gt, cmp.o_eq, cmp.o_lt, cmp.bits_used}), 0);
        chk("model_k_8000", calc_k(16'h8000, 16'h7FFF), 1);
        chk("model_k_1230", calc_k(16'h1230, 16'h1240), 10);
        chk("model_k_equal", calc_k(16'hA5A5, 16'hA5A5), 16);
        @(posedge clk); #3;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("idle_hold", int'({cmp.busy, cmp.done, cmp.o_gt, cmp.o_eq, cmp.o_lt, cmp.bits_used}), 0);

        directed("msb_gt", 16'h8000, 16'h7FFF, 1, 3'b100, 0);
        directed("equal_a5a5", 16'hA5A5, 16'hA5A5, 16, 3'b010, 0);
        directed("lt_lsb", 16'h0000, 16'h0001, 16, 3'b001, 0);
        directed("lt_1230", 16'h1230, 16'h1240, 10, 3'b001, 0);
        directed("midrun_poke", 16'h1230, 16'h1240, 10, 3'b001, 3);

        // Reset during the fifth RUN cycle of an equal compare.
        @(posedge clk); #3;
        cmp.x = 16'hA5A5; cmp.y = 16'hA5A5; cmp.start = 1'b1;
        @(posedge clk); #3;
        cmp.start = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("midrun_reset", int'({cmp.busy, cmp.done, cmp.o_gt, cmp.o_eq, cmp.o_lt, cmp.bits_used}), 0);
        @(posedge clk); #3;
        rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (cmp.done) dones++;
        end
        chk("no_done_after_reset", dones, 0);
        directed("after_reset_gt", 16'h0003, 16'h0002, 16, 3'b100, 0);

        // Back-to-back random compares with start held high; operands change every cycle.
        @(posedge clk); #3;
        b2b = 1; have_prev = 0;
        base = m_accepts;
        cmp.start = 1'b1;
        for (int c = 0; c < 80000 && (m_accepts - base) < 10000; c++) begin
            r = $urandom;
            cmp.x = r[15:0];
            case ($urandom_range(0, 15))
                0:       cmp.y = r[15:0];
                1:       cmp.y = r[15:0] ^ (16'h0001 << $urandom_range(0, 15));
                default: cmp.y = 16'($urandom);
            endcase
            @(posedge clk); #3;
        end
        cmp.start = 1'b0;
        chk("random_accepts", m_accepts - base, 10000);
        repeat (40) @(posedge clk);
        #3;
        b2b = 0;
        chk("final_idle", int'(cmp.busy), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
